port_alloc_rr: RTL and testbench

Parametrised, registered port allocator for the bufferless deflection router. Each cycle it takes up to NUM_CH incoming flits, each with a productive-port request vector, and gives every valid flit exactly one output: a free productive port, a deflection port, or the bypass lane. Channel priority rotates round-robin, so no input channel starves under contention. It sits between route computation and the crossbar, replacing the fixed-priority combinational allocator and adding one pipeline register.

---
 rtl/port_alloc_rr.sv | 152 +++++++++++++++
 tb/tb_port_alloc_rr.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/port_alloc_rr.sv
// Registered round-robin port allocator for the deflection router: one grant per valid flit.
// Optional deflection/bypass statistics are built when PA_DEFLECT_STAT_EN is defined.
module port_alloc_rr #(
  parameter int NUM_CH  = 5,
  parameter int NUM_OUT = 5
`ifdef PA_DEFLECT_STAT_EN
  , parameter int CNT_W = 16
`endif
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               alloc_en,
  input  logic                               flush,
  input  logic [NUM_CH-1:0]                  valid_in,
  input  logic [NUM_CH*NUM_OUT-1:0]          pv_in,
  output logic [NUM_CH*(NUM_OUT+1)-1:0]      pv_out,
  output logic                               out_valid,
  output logic [$clog2(NUM_CH)-1:0]          rr_ptr
`ifdef PA_DEFLECT_STAT_EN
  , output logic [NUM_CH*CNT_W-1:0]          defl_cnt,
  output logic [CNT_W-1:0]                   byp_cnt
`endif
);

  localparam int PTR_W = $clog2(NUM_CH);
  localparam int GW    = NUM_OUT + 1;

  logic [NUM_OUT-1:0]     req [NUM_CH];
  logic [GW-1:0]          gnt_next [NUM_CH];
  logic [NUM_CH*GW-1:0]   pv_next;
  logic [NUM_CH*GW-1:0]   pv_reg;
  logic                   out_valid_reg;
  logic [PTR_W-1:0]       ptr_reg;
  logic [PTR_W-1:0]       ptr_inc;

  logic [NUM_OUT-1:0]     free;
  logic [NUM_OUT-1:0]     prod;
  logic [NUM_OUT-1:0]     pick;
  logic [PTR_W:0]         csum;
  logic [PTR_W-1:0]       ch;
`ifdef PA_DEFLECT_STAT_EN
  logic [NUM_CH-1:0]      defl_next;
  logic [PTR_W:0]         nbyp_next;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_pack
      assign req[gi]                = pv_in[gi*NUM_OUT +: NUM_OUT];
      assign pv_next[gi*GW +: GW]   = gnt_next[gi];
    end
  endgenerate

  // Channels are visited in priority order; each grant removes its port from the free set.
  always_comb begin
    free = '1;
    prod = '0;
    pick = '0;
    csum = '0;
    ch   = '0;
`ifdef PA_DEFLECT_STAT_EN
    defl_next = '0;
    nbyp_next = '0;
`endif
    for (int i = 0; i < NUM_CH; i++) gnt_next[i] = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      csum = {1'b0, ptr_reg} + (PTR_W+1)'(k);
      if (csum >= (PTR_W+1)'(NUM_CH)) csum = csum - (PTR_W+1)'(NUM_CH);
      ch   = csum[PTR_W-1:0];
      prod = req[ch] & free;
      pick = '0;
      for (int b = 0; b < NUM_OUT; b++) begin
        if (prod[b]) begin
          pick    = '0;
          pick[b] = 1'b1;
        end
      end
      // Deflection prefers the lowest free port and never uses the ejection port.
      if (prod == '0) begin
        for (int b = NUM_OUT - 2; b >= 0; b--) begin
          if (free[b]) begin
            pick    = '0;
            pick[b] = 1'b1;
          end
        end
      end
      if (valid_in[ch]) begin
        gnt_next[ch] = {~|pick, pick};
        free         = free & ~pick;
`ifdef PA_DEFLECT_STAT_EN
        if (prod == '0) defl_next[ch] = 1'b1;
        if (~|pick)     nbyp_next     = nbyp_next + 1'b1;
`endif
      end
    end
  end

  assign ptr_inc = (ptr_reg == PTR_W'(NUM_CH - 1)) ? '0 : ptr_reg + 1'b1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pv_reg        <= '0;
      out_valid_reg <= 1'b0;
      ptr_reg       <= '0;
    end else if (flush) begin
      pv_reg        <= '0;
      out_valid_reg <= 1'b0;
      ptr_reg       <= '0;
    end else if (alloc_en) begin
      pv_reg        <= pv_next;
      out_valid_reg <= 1'b1;
      if (|valid_in) ptr_reg <= ptr_inc;
    end
  end

  assign pv_out    = pv_reg;
  assign out_valid = out_valid_reg;
  assign rr_ptr    = ptr_reg;

`ifdef PA_DEFLECT_STAT_EN
  // Counters only advance on allocations that actually commit (flush suppresses them).
  logic [CNT_W-1:0] defl_cnt_reg [NUM_CH];
  logic [CNT_W-1:0] byp_cnt_reg;
  logic [CNT_W:0]   byp_sum;

  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_defl
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          defl_cnt_reg[gi] <= '0;
        end else if (alloc_en && !flush && defl_next[gi] && (defl_cnt_reg[gi] != '1)) begin
          defl_cnt_reg[gi] <= defl_cnt_reg[gi] + 1'b1;
        end
      end
      assign defl_cnt[gi*CNT_W +: CNT_W] = defl_cnt_reg[gi];
    end
  endgenerate

  assign byp_sum = {1'b0, byp_cnt_reg} + (CNT_W+1)'(nbyp_next);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      byp_cnt_reg <= '0;
    end else if (alloc_en && !flush) begin
      byp_cnt_reg <= byp_sum[CNT_W] ? '1 : byp_sum[CNT_W-1:0];
    end
  end

  assign byp_cnt = byp_cnt_reg;
`endif

endmodule

// File: tb/tb_port_alloc_rr.sv
// Bench for port_alloc_rr: directed vector table, async reset check, then random traffic
// against a behavioural allocation model (plus counter checks when PA_DEFLECT_STAT_EN is set).
module tb_port_alloc_rr;

  localparam int NC = 5;
  localparam int NO = 5;
  localparam int GW = NO + 1;
  localparam int PW = 3;
`ifdef PA_DEFLECT_STAT_EN
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;
`endif

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              alloc_en = 1'b0;
  logic              flush = 1'b0;
  logic [NC-1:0]     valid_in = '0;
  logic [NC*NO-1:0]  pv_in = '0;
  logic [NC*GW-1:0]  pv_out;
  logic              out_valid;
  logic [PW-1:0]     rr_ptr;
`ifdef PA_DEFLECT_STAT_EN
  logic [NC*CW-1:0]  defl_cnt;
  logic [CW-1:0]     byp_cnt;
`endif

  port_alloc_rr #(
    .NUM_CH (NC),
    .NUM_OUT(NO)
`ifdef PA_DEFLECT_STAT_EN
    , .CNT_W(CW)
`endif
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .alloc_en (alloc_en),
    .flush    (flush),
    .valid_in (valid_in),
    .pv_in    (pv_in),
    .pv_out   (pv_out),
    .out_valid(out_valid),
    .rr_ptr   (rr_ptr)
`ifdef PA_DEFLECT_STAT_EN
    , .defl_cnt(defl_cnt),
    .byp_cnt  (byp_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic             en;
    logic             fl;
    logic [NC-1:0]    v;
    logic [NC*NO-1:0] pv;
    logic [NC*GW-1:0] g;
    logic             ov;
    logic [PW-1:0]    ptr;
  } vec_t;

  vec_t tbl[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Reference model state
  logic [NC*GW-1:0] m_pv  = '0;
  logic             m_ov  = 1'b0;
  int               m_ptr = 0;
`ifdef PA_DEFLECT_STAT_EN
  int               m_defl[NC];
  int               m_byp = 0;
`endif

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", nm, act, exp);
    end
  endtask

  task automatic add(input logic en, input logic fl, input logic [NC-1:0] v,
                     input logic [NC*NO-1:0] pv, input logic [NC*GW-1:0] g,
                     input logic ov, input logic [PW-1:0] ptr);
    vec_t t;
    t.en = en; t.fl = fl; t.v = v; t.pv = pv; t.g = g; t.ov = ov; t.ptr = ptr;
    tbl.push_back(t);
  endtask

  // Walks channels in priority order with an explicit list of taken ports.
  function automatic void model(input logic [NC-1:0] v, input logic [NC*NO-1:0] pv, input int ptr,
                                output logic [NC*GW-1:0] g, output logic [NC-1:0] dfl,
                                output int nbyp);
    bit taken[NO];
    int c;
    int pick;
    g = '0; dfl = '0; nbyp = 0;
    for (int p = 0; p < NO; p++) taken[p] = 1'b0;
    for (int k = 0; k < NC; k++) begin
      c = (ptr + k) % NC;
      if (!v[c]) continue;
      pick = -1;
      for (int p = NO - 1; p >= 0; p--)
        if (pv[c*NO + p] && !taken[p]) begin pick = p; break; end
      if (pick < 0) begin
        dfl[c] = 1'b1;
        for (int p = 0; p <= NO - 2; p++)
          if (!taken[p]) begin pick = p; break; end
      end
      if (pick < 0) begin
        g[c*GW + NO] = 1'b1;
        nbyp++;
      end else begin
        taken[pick] = 1'b1;
        g[c*GW + pick] = 1'b1;
      end
    end
  endfunction

  task automatic step(input logic e, input logic f, input logic [NC-1:0] v, input logic [NC*NO-1:0] p);
    logic [NC*GW-1:0] g;
    logic [NC-1:0]    d;
    int               nb;
    alloc_en = e; flush = f; valid_in = v; pv_in = p;
    model(v, p, m_ptr, g, d, nb);
    if (f) begin
      m_pv = '0; m_ov = 1'b0; m_ptr = 0;
    end else if (e) begin
      m_pv = g; m_ov = 1'b1;
      if (|v) m_ptr = (m_ptr + 1) % NC;
`ifdef PA_DEFLECT_STAT_EN
      for (int c = 0; c < NC; c++) if (d[c] && m_defl[c] < CMAX) m_defl[c]++;
      m_byp = (m_byp + nb > CMAX) ? CMAX : m_byp + nb;
`endif
    end
    @(negedge clk);
    $display("step en=%0b fl=%0b v=%b pv=%h -> pv_out=%h ov=%0b ptr=%0d",
             e, f, v, p, pv_out, out_valid, rr_ptr);
    chk("pv_out", 64'(pv_out), 64'(m_pv));
    chk("out_valid", 64'(out_valid), 64'(m_ov));
    chk("rr_ptr", 64'(rr_ptr), 64'(m_ptr));
`ifdef PA_DEFLECT_STAT_EN
    for (int c = 0; c < NC; c++) chk("defl_cnt", 64'(defl_cnt[c*CW +: CW]), 64'(m_defl[c]));
    chk("byp_cnt", 64'(byp_cnt), 64'(m_byp));
`endif
  endtask

  initial begin
    logic [31:0] r1, r2, r3;
    logic [NC*NO-1:0] rp;

    // {ch4, ch3, ch2, ch1, ch0} in every packed field below
    add(1, 0, 5'b00011, {5'b0, 5'b0, 5'b0, 5'b01000, 5'b00100},
        {6'b0, 6'b0, 6'b0, 6'b001000, 6'b000100}, 1, 3'd1);
    add(1, 1, 5'b00011, {5'b0, 5'b0, 5'b0, 5'b01000, 5'b00100}, '0, 0, 3'd0);
    add(1, 0, 5'b00011, {5'b0, 5'b0, 5'b0, 5'b00010, 5'b00010},
        {6'b0, 6'b0, 6'b0, 6'b000001, 6'b000010}, 1, 3'd1);
    add(1, 0, 5'b00011, {5'b0, 5'b0, 5'b0, 5'b00010, 5'b00010},
        {6'b0, 6'b0, 6'b0, 6'b000010, 6'b000001}, 1, 3'd2);
    add(1, 1, 5'b00000, '0, '0, 0, 3'd0);
    add(1, 0, 5'b11111, {5{5'b10000}},
        {6'b001000, 6'b000100, 6'b000010, 6'b000001, 6'b010000}, 1, 3'd1);
    add(1, 1, 5'b00000, '0, '0, 0, 3'd0);
    add(1, 0, 5'b11111, {5{5'b00001}},
        {6'b100000, 6'b001000, 6'b000100, 6'b000010, 6'b000001}, 1, 3'd1);
    for (int i = 0; i < 3; i++)
      add(0, 0, 5'b11111, {5{5'b11111}},
          {6'b100000, 6'b001000, 6'b000100, 6'b000010, 6'b000001}, 1, 3'd1);
    add(1, 1, 5'b11111, {5{5'b11111}}, '0, 0, 3'd0);
    add(1, 0, 5'b00000, {5{5'b11111}}, '0, 1, 3'd0);
    for (int i = 1; i <= 5; i++)
      add(1, 0, 5'b00001, {5'b0, 5'b0, 5'b0, 5'b0, 5'b00001},
          {6'b0, 6'b0, 6'b0, 6'b0, 6'b000001}, 1, PW'(i % NC));
    add(1, 0, 5'b00100, '0, {6'b0, 6'b0, 6'b000001, 6'b0, 6'b0}, 1, 3'd1);
    add(1, 0, 5'b00011, {5'b0, 5'b0, 5'b0, 5'b10001, 5'b10000},
        {6'b0, 6'b0, 6'b0, 6'b010000, 6'b000001}, 1, 3'd2);

    // Reset state
    repeat (2) @(negedge clk);
    chk("reset pv_out", 64'(pv_out), 64'd0);
    chk("reset out_valid", 64'(out_valid), 64'd0);
    chk("reset rr_ptr", 64'(rr_ptr), 64'd0);
`ifdef PA_DEFLECT_STAT_EN
    chk("reset defl_cnt", 64'(defl_cnt), 64'd0);
    chk("reset byp_cnt", 64'(byp_cnt), 64'd0);
    for (int c = 0; c < NC; c++) m_defl[c] = 0;
`endif
    reset = 1'b1;
    @(negedge clk);

    foreach (tbl[i]) begin
      alloc_en = tbl[i].en; flush = tbl[i].fl; valid_in = tbl[i].v; pv_in = tbl[i].pv;
      @(negedge clk);
      $display("vec %0d: pv_out=%h ov=%0b ptr=%0d", i, pv_out, out_valid, rr_ptr);
      chk($sformatf("vec%0d pv_out", i), 64'(pv_out), 64'(tbl[i].g));
      chk($sformatf("vec%0d out_valid", i), 64'(out_valid), 64'(tbl[i].ov));
      chk($sformatf("vec%0d rr_ptr", i), 64'(rr_ptr), 64'(tbl[i].ptr));
    end

    // Reset asserted between edges must clear outputs without a clock edge
    alloc_en = 1'b1; flush = 1'b0; valid_in = 5'b11111; pv_in = {5{5'b00100}};
    @(posedge clk);
    #1;
    chk("pre-reset out_valid", 64'(out_valid), 64'd1);
    #1 reset = 1'b0;
    #1;
    $display("async reset: pv_out=%h ov=%0b ptr=%0d", pv_out, out_valid, rr_ptr);
    chk("async pv_out", 64'(pv_out), 64'd0);
    chk("async out_valid", 64'(out_valid), 64'd0);
    chk("async rr_ptr", 64'(rr_ptr), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    m_pv = '0; m_ov = 1'b0; m_ptr = 0;
`ifdef PA_DEFLECT_STAT_EN
    chk("async defl_cnt", 64'(defl_cnt), 64'd0);
    chk("async byp_cnt", 64'(byp_cnt), 64'd0);
    for (int c = 0; c < NC; c++) m_defl[c] = 0;
    m_byp = 0;
`endif

    // Random traffic, biased towards contention
    for (int i = 0; i < 300; i++) begin
      r1 = $urandom; r2 = $urandom; r3 = $urandom;
      rp = (r1[0]) ? r2[NC*NO-1:0] : (r2[NC*NO-1:0] & r3[NC*NO-1:0] & 25'($urandom));
      step(r1[3:1] != 3'd0, r1[7:4] == 4'd0, r1[12:8], rp);
    end

`ifdef PA_DEFLECT_STAT_EN
    // Channel 1 deflected every cycle: its counter must pin at the maximum
    for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 5'b00010, '0);
    chk("defl_cnt ch1 saturated", 64'(defl_cnt[1*CW +: CW]), 64'(CMAX));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
